uart_rx: RTL and testbench
==========================

# uart_rx

Receive-side counterpart of the 3 Mbaud UART transmitter: it deserialises 8N1 frames from the FTDI serial line into bytes. It runs on the system clock and oversamples the line `CLKS_PER_BIT` times per bit. No baud clock enable is needed. Received bytes go to the fabric through a valid/ready handshake, buffered in a holding register or an optional FIFO. Framing errors and overruns are flagged as single-cycle pulses.

## Interface
- `CLKS_PER_BIT`, 4, system clocks per bit (12 MHz / 3 Mbaud); must be ≥ 4 and even.
- `FIFO_DEPTH`, 4, FIFO entries when `UART_RX_FIFO_EN` is defined; power of two, ≥ 2.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous and active-high.
- `ftdi_rx`  in  1  asynchronous serial line; idles high.
- `data`  out  8  received byte; valid while `valid` is high.
- `valid`  out  1  byte available.
- `ready`  in  1  consumer accepts `data` when `valid && ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: completed byte dropped because the buffer was full.

## Operation
- **Input synchroniser:** two flops on `ftdi_rx` produce `rx_s`. Both flops reset to 1.
- **Counters:** bit-time counter `cnt` is 0..CLKS_PER_BIT-1. Bit index `idx` is 0..7.
- **State machine:** states IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: `rx_s==0` → START, with `cnt=0`.
  - START: when `cnt==CLKS_PER_BIT/2-1`, sample `rx_s`.
    - Sample 1: false start; go to IDLE, nothing reported.
    - Sample 0: go to DATA with `cnt=0`, `idx=0`.
  - DATA: when `cnt==CLKS_PER_BIT-1`, shift `rx_s` into the shift register LSB-first and reset `cnt`.
    - After `idx==7` is sampled, go to STOP.
  - STOP: when `cnt==CLKS_PER_BIT-1`, sample `rx_s`.
    - Sample 1: commit the byte and go to IDLE.
    - Sample 0: pulse `frame_err`, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s==1` (break or stuck-low line), then go to IDLE.
- **Stop bits:** only one stop bit is required. The transmitter's extra stop bits are treated as idle. Returning to IDLE at mid-stop lets the next start edge be detected with half a bit of margin.
- **Commit into the buffer:**
  - If the buffer has space, or one entry is popped in the same cycle (`valid && ready`), the byte is stored.
  - Otherwise pulse `overrun`, drop the new byte, and keep the buffered contents unchanged.
- **Output stability:** `data` stays stable while `valid && !ready`.
- **Reset values:** `valid=0`, `data=8'h00`, `frame_err=0`, `overrun=0`. The state machine is in IDLE and the buffer is empty.
- **Reset mid-frame:** discard the partial byte and all buffered bytes. The next frame is received normally once `rx_s` has been observed high after reset.

## Timing
- **Synchroniser latency:** 2 clocks from an `ftdi_rx` edge to `rx_s`.
- **Sample points:** start bit at edge+CLKS_PER_BIT/2. Data bit n at edge+CLKS_PER_BIT/2+(n+1)·CLKS_PER_BIT. The edge is taken at `rx_s`.
- **Commit timing:** if the stop sample occurs at cycle S:
  - `valid` rises at S+1, with the byte on `data`.
  - `frame_err` or `overrun` pulses high during cycle S+1 only.
- **Handshake:** `valid` drops the cycle after `valid && ready` if no further byte is buffered.
- **Throughput:** back-to-back frames with one stop bit are sustained indefinitely while `ready` is held high.
- **Simultaneous events:** commit and pop in the same cycle on a full buffer is legal. There is no overrun, and the new byte becomes the next entry.

## Configuration
- **`UART_RX_FIFO_EN` undefined:** the buffer is a single holding register (depth 1).
- **`UART_RX_FIFO_EN` defined:** the buffer is a `FIFO_DEPTH`-entry first-word-fall-through FIFO.
  - `valid` = not empty; `data` = head entry.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - Full/empty are distinguished by an extra pointer bit.
  - `overrun` is raised only when the FIFO holds `FIFO_DEPTH` entries and no pop occurs that cycle.

## Test plan
- **Single byte:** send 0x55 at 4 clocks/bit with 1 stop bit, `ready=1` → one `valid` pulse with `data=0x55`; `frame_err=0`, `overrun=0`.
- **Back-to-back:** send 0x41, 0xA5, 0x00, 0xFF with 1 stop bit and no idle gap, `ready=1` → four handshakes in order, no errors.
- **Glitch:** drive the line low for 1 clock, then high → no state change beyond START, no `valid`, no pulses.
- **Framing error:** send 0x3C with the stop bit 0, then hold the line low 40 clocks, then send 0x12 → one `frame_err` and no `valid` for 0x3C; nothing during the low period; 0x12 is then received correctly.
- **Overrun:** hold `ready=0` and send 0x11, 0x22.
  - No FIFO: `data` stays 0x11 and `overrun` pulses once for 0x22.
  - With FIFO (depth 4): send 5 bytes; `overrun` fires on the 5th; raising `ready` then drains the first 4 bytes in order.
- **Reset mid-frame:** assert `rst` during bit 3 of 0x99 → `valid=0`, buffer empty; the next 0x5A is received intact.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver that oversamples the line CLKS_PER_BIT times per bit.
// Received bytes are handed to the fabric over a valid/ready handshake.
//
// Parameters:
//   CLKS_PER_BIT  system clocks per bit (>= 4, even)
//   FIFO_DEPTH    receive FIFO entries when UART_RX_FIFO_EN is defined (power of two, >= 2)
//
// Configuration macro:
//   UART_RX_FIFO_EN  undefined -> single holding register
//                    defined   -> FIFO_DEPTH-entry first-word-fall-through FIFO
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   ftdi_rx    asynchronous serial line, idles high
//   data       received byte, valid while valid is high
//   valid      byte available
//   ready      consumer accepts data when valid && ready
//   frame_err  one-cycle pulse: stop bit sampled low
//   overrun    one-cycle pulse: completed byte dropped, buffer full
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ftdi_rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_cpb
        $error("uart_rx: CLKS_PER_BIT must be >= 4 and even");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    // ---------------- input synchroniser ----------------
    logic rx_meta;
    logic rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= ftdi_rx;
            rx_s    <= rx_meta;
        end
    end

    // ---------------- receive FSM ----------------
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          commit;
    logic          ferr_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        commit  = 1'b0;
        ferr_n  = 1'b0;
        unique case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (!rx_s) begin
                    state_n = S_START;
                end
            end
            S_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_n = '0;
                    idx_n = '0;
                    // Line back high at mid-start: treat as a glitch.
                    state_n = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt == CNT_MAX) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s, shreg[7:1]};
                    idx_n   = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_n = S_STOP;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt == CNT_MAX) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        // Leave at mid-stop so the next start edge has half a bit of margin.
                        commit  = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_WAIT_IDLE: begin
                cnt_n = '0;
                if (rx_s) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= ferr_n;
        end
    end

    // ---------------- output buffer ----------------
    logic pop;
    assign pop = valid && ready;

`ifdef UART_RX_FIFO_EN
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        empty;
    logic        full;
    logic        push;

    // Extra MSB on each pointer separates full (MSBs differ) from empty (equal).
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign push  = commit && (!full || pop);
    assign valid = !empty;
    assign data  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            overrun <= 1'b0;
            mem     <= '{default: '0};
        end else begin
            overrun <= commit && full && !pop;
            if (push) begin
                mem[wptr[AW-1:0]] <= shreg;
                wptr              <= wptr + {{AW{1'b0}}, 1'b1};
            end
            if (pop) begin
                rptr <= rptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (commit) begin
                if (!valid || pop) begin
                    data  <= shreg;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (pop) begin
                valid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus a randomized frame
// stream, compared against a byte-level queue model of the receive buffer.
module tb_uart_rx;

    localparam int unsigned CPB = 4;
    localparam int unsigned FD  = 4;
`ifdef UART_RX_FIFO_EN
    localparam int unsigned BUF_DEPTH = FD;
`else
    localparam int unsigned BUF_DEPTH = 1;
`endif
    // Cycles from driving the start bit to valid being visible:
    // 2 sync + CPB/2 to mid-start + 9 bit times to mid-stop + 1 register stage.
    localparam int unsigned LATENCY = 3 + CPB / 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       ftdi_rx;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;

    always #5 clk = ~clk;

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ftdi_rx  (ftdi_rx),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [7:0]  exp_q[$];
    int unsigned exp_fe  = 0;
    int unsigned exp_ov  = 0;
    int unsigned fe_seen = 0;
    int unsigned ov_seen = 0;

    int unsigned cyc      = 0;
    int unsigned rise_cyc = 0;
    logic        hold_d   = 1'b0;
    logic        valid_d  = 1'b0;
    logic [7:0]  data_d   = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sampled mid-cycle, scores handshakes and pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid && !valid_d) rise_cyc = cyc;
            if (frame_err) fe_seen++;
            if (overrun) ov_seen++;
            if (hold_d) begin
                check("hold_valid", valid, 1'b1);
                check("hold_data", data, data_d);
            end
            if (valid && ready) begin
                if (exp_q.size() == 0) check("spurious_byte", 1'b1, 1'b0);
                else check("rx_byte", data, exp_q.pop_front());
            end
            hold_d  = valid && !ready;
            valid_d = valid;
            data_d  = data;
        end else begin
            hold_d  = 1'b0;
            valid_d = 1'b0;
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one frame and record what the receiver should do with it.
    task automatic frame(input logic [7:0] b, input bit stop_ok,
                         input int unsigned low_hold, input int unsigned idle);
        if (stop_ok) begin
            if (ready || exp_q.size() < BUF_DEPTH) exp_q.push_back(b);
            else exp_ov++;
        end else begin
            exp_fe++;
        end
        ftdi_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            ftdi_rx = b[i];
            tick(CPB);
        end
        ftdi_rx = stop_ok;
        tick(CPB);
        if (!stop_ok) tick(low_hold);
        ftdi_rx = 1'b1;
        tick(idle);
    endtask

    task automatic end_phase(input string tag);
        tick(6 * CPB);
        check({tag, "_drained"}, exp_q.size(), 0);
        check({tag, "_frame_err"}, fe_seen, exp_fe);
        check({tag, "_overrun"}, ov_seen, exp_ov);
    endtask

    initial begin
        rst     = 1'b1;
        ftdi_rx = 1'b1;
        ready   = 1'b1;
        tick(5);
        check("rst_valid", valid, 1'b0);
        check("rst_data", data, 8'h00);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        rst = 1'b0;
        tick(5);

        // Single byte with latency check.
        rise_cyc = 0;
        begin
            int unsigned t0;
            t0 = cyc;
            frame(8'h55, 1'b1, 0, CPB);
            tick(3 * CPB);
            check("latency", rise_cyc - t0, LATENCY);
        end
        end_phase("single");

        // Back-to-back, one stop bit, no gap.
        frame(8'h41, 1'b1, 0, 0);
        frame(8'hA5, 1'b1, 0, 0);
        frame(8'h00, 1'b1, 0, 0);
        frame(8'hFF, 1'b1, 0, 0);
        end_phase("b2b");

        // One-clock glitch.
        ftdi_rx = 1'b0;
        tick(1);
        ftdi_rx = 1'b1;
        tick(4 * CPB);
        check("glitch_valid", valid, 1'b0);
        end_phase("glitch");

        // Framing error, long low, then a good byte.
        frame(8'h3C, 1'b0, 40, 2 * CPB);
        check("ferr_valid", valid, 1'b0);
        frame(8'h12, 1'b1, 0, CPB);
        end_phase("ferr");

        // Overrun: ready held low, one byte more than the buffer holds.
        ready = 1'b0;
        for (int unsigned i = 0; i <= BUF_DEPTH; i++) begin
            logic [7:0] b;
            b = 8'(8'h11 * (i + 1));
            frame(b, 1'b1, 0, CPB);
        end
        tick(4 * CPB);
        check("ovr_valid", valid, 1'b1);
        check("ovr_head", data, 8'h11);
        check("ovr_count", ov_seen, exp_ov);
        ready = 1'b1;
        end_phase("overrun");

        // Reset mid-frame with a byte already buffered.
        ready = 1'b0;
        frame(8'h77, 1'b1, 0, CPB);
        begin
            logic [7:0] b;
            b = 8'h99;
            ftdi_rx = 1'b0;
            tick(CPB);
            for (int i = 0; i < 3; i++) begin
                ftdi_rx = b[i];
                tick(CPB);
            end
            ftdi_rx = b[3];
            tick(CPB / 2);
        end
        rst     = 1'b1;
        ftdi_rx = 1'b1;
        tick(3);
        exp_q.delete();
        rst   = 1'b0;
        ready = 1'b1;
        tick(1);
        check("midrst_valid", valid, 1'b0);
        tick(2 * CPB);
        frame(8'h5A, 1'b1, 0, CPB);
        end_phase("midrst");

        // Randomized stream, ready held high.
        for (int n = 0; n < 30; n++) begin
            logic [7:0]  b;
            bit          ok;
            int unsigned gap;
            b   = 8'($urandom);
            ok  = ($urandom_range(0, 5) != 0);
            gap = CPB * $urandom_range(0, 2) + $urandom_range(0, 3);
            if (ok) frame(b, 1'b1, 0, gap);
            else frame(b, 1'b0, $urandom_range(0, 20), CPB + gap);
        end
        end_phase("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
